// File: rtl/z80_bus_ctrl.sv
// Reset sequencer, per-space wait-state generator and bus strobes for fz80.
// Counts completed bus accesses in the cpu_clk domain.
module z80_bus_ctrl #(
   parameter int RST_CYCLES = 8,
   parameter int MEM_WAIT   = 0,
   parameter int IO_WAIT    = 1
) (
   input  logic        n_RST,
   input  logic        cpu_clk,
   input  logic        soft_rst,
   input  logic        cpu_mreq,
   input  logic        cpu_ioreq,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   output logic        cpu_rst,
   output logic        cpu_wait,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        io_rd,
   output logic        io_wr,
   output logic [15:0] acc_cnt
);

   localparam logic [7:0] RST_N = 8'(RST_CYCLES);
   localparam logic [3:0] MEM_W = 4'(MEM_WAIT);
   localparam logic [3:0] IO_W  = 4'(IO_WAIT);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] rst_cnt;
   logic [7:0] rst_cnt_nxt;
   logic [3:0] wcnt;
   logic [3:0] wcnt_nxt;
   logic [3:0] w;
   logic       access;
   logic       force_idle;
   logic       stale;
   logic       stale_nxt;
   logic       start;
   logic       cnt_inc;

   always_comb begin
      rst_cnt_nxt = rst_cnt;
      if (soft_rst)
         rst_cnt_nxt = '0;
      else if (rst_cnt < RST_N)
         rst_cnt_nxt = rst_cnt + 8'd1;
   end

   always_ff @(posedge cpu_clk or negedge n_RST) begin
      if (!n_RST) begin
         rst_cnt <= '0;
         cpu_rst <= 1'b1;
      end else begin
         rst_cnt <= rst_cnt_nxt;
         cpu_rst <= (rst_cnt_nxt != RST_N);
      end
   end

   assign access     = (cpu_mreq | cpu_ioreq) & (cpu_rd | cpu_wr);
   assign w          = cpu_ioreq ? IO_W : MEM_W;
   assign force_idle = cpu_rst | soft_rst;
   // A strobe that straddles reset must drop before it can start a cycle
   assign stale_nxt  = access & (stale | force_idle);
   assign start      = access & ~cpu_rst & ~stale;

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      cnt_inc   = 1'b0;
      if (force_idle) begin
         state_nxt = IDLE;
         wcnt_nxt  = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (w != 4'd0) begin
                     state_nxt = WAIT;
                     wcnt_nxt  = w - 4'd1;
                  end else begin
                     state_nxt = HOLD;
                     cnt_inc   = 1'b1;
                  end
               end
            end
            WAIT: begin
               if (!access) begin
                  state_nxt = IDLE;
               end else if (wcnt == 4'd0) begin
                  state_nxt = HOLD;
                  cnt_inc   = 1'b1;
               end else begin
                  wcnt_nxt = wcnt - 4'd1;
               end
            end
            HOLD: begin
               if (!access)
                  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge cpu_clk or negedge n_RST) begin
      if (!n_RST) begin
         state   <= IDLE;
         wcnt    <= '0;
         stale   <= 1'b0;
         acc_cnt <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         stale <= stale_nxt;
         if (cnt_inc)
            acc_cnt <= acc_cnt + 16'd1;
      end
   end

   assign cpu_wait = ((state == IDLE) & start & (w != 4'd0))
                   | ((state == WAIT) & (wcnt != 4'd0) & access);

   assign mem_rd = cpu_mreq  & cpu_rd & ~cpu_rst;
   assign mem_wr = cpu_mreq  & cpu_wr & ~cpu_rst;
   assign io_rd  = cpu_ioreq & cpu_rd & ~cpu_rst;
   assign io_wr  = cpu_ioreq & cpu_wr & ~cpu_rst;

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Bench for z80_bus_ctrl: two instances (IO 3/MEM 0 and IO 5/MEM 2)
// share stimulus; acc_cnt expectations flow through scoreboard queues.
module tb_z80_bus_ctrl;

   logic clk = 1'b0;
   logic n_rst, soft_rst, mreq, ioreq, rd, wr;
   logic a_rst, a_wait, a_mrd, a_mwr, a_ird, a_iwr;
   logic b_rst, b_wait, b_mrd, b_mwr, b_ird, b_iwr;
   logic [15:0] a_cnt, b_cnt;

   int checks = 0;
   int errors = 0;
   logic [15:0] cnt_a = '0;
   logic [15:0] cnt_b = '0;
   logic [15:0] q_a[$];
   logic [15:0] q_b[$];

   always #5 clk = ~clk;

   z80_bus_ctrl #(.RST_CYCLES(8), .MEM_WAIT(0), .IO_WAIT(3)) u_a (
      .n_RST(n_rst), .cpu_clk(clk), .soft_rst(soft_rst),
      .cpu_mreq(mreq), .cpu_ioreq(ioreq), .cpu_rd(rd), .cpu_wr(wr),
      .cpu_rst(a_rst), .cpu_wait(a_wait),
      .mem_rd(a_mrd), .mem_wr(a_mwr), .io_rd(a_ird), .io_wr(a_iwr),
      .acc_cnt(a_cnt)
   );

   z80_bus_ctrl #(.RST_CYCLES(8), .MEM_WAIT(2), .IO_WAIT(5)) u_b (
      .n_RST(n_rst), .cpu_clk(clk), .soft_rst(soft_rst),
      .cpu_mreq(mreq), .cpu_ioreq(ioreq), .cpu_rd(rd), .cpu_wr(wr),
      .cpu_rst(b_rst), .cpu_wait(b_wait),
      .mem_rd(b_mrd), .mem_wr(b_mwr), .io_rd(b_ird), .io_wr(b_iwr),
      .acc_cnt(b_cnt)
   );

   // One access of ncyc cycles followed by one idle cycle.
   task automatic run_access(input logic m, input logic io, input logic r,
                             input logic w_i, input int ncyc,
                             input string tag);
      int wa, wb;
      logic [3:0] sexp;
      logic [15:0] ea, eb;
      wa = io ? 3 : 0;
      wb = io ? 5 : 2;
      sexp = {m & r, m & w_i, io & r, io & w_i};
      if (ncyc > wa) cnt_a++;
      q_a.push_back(cnt_a);
      if (ncyc > wb) cnt_b++;
      q_b.push_back(cnt_b);
      mreq = m; ioreq = io; rd = r; wr = w_i;
      for (int i = 0; i < ncyc; i++) begin
         #1;
         checks++;
         if (a_wait !== (i < wa)) begin
            errors++;
            $display("FAIL %s wait_a cyc %0d got %b want %b",
                     tag, i, a_wait, (i < wa));
         end
         checks++;
         if (b_wait !== (i < wb)) begin
            errors++;
            $display("FAIL %s wait_b cyc %0d got %b want %b",
                     tag, i, b_wait, (i < wb));
         end
         checks++;
         if ({a_mrd, a_mwr, a_ird, a_iwr} !== sexp ||
             {b_mrd, b_mwr, b_ird, b_iwr} !== sexp) begin
            errors++;
            $display("FAIL %s strobes cyc %0d got %b/%b want %b", tag, i,
                     {a_mrd, a_mwr, a_ird, a_iwr},
                     {b_mrd, b_mwr, b_ird, b_iwr}, sexp);
         end
         @(posedge clk); #1;
      end
      mreq = 0; ioreq = 0; rd = 0; wr = 0;
      #1;
      checks++;
      if (a_wait !== 1'b0 || b_wait !== 1'b0) begin
         errors++;
         $display("FAIL %s wait_drop got %b/%b want 0/0",
                  tag, a_wait, b_wait);
      end
      @(posedge clk); #1;
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      checks++;
      if (a_cnt !== ea || b_cnt !== eb) begin
         errors++;
         $display("FAIL %s acc_cnt got %h/%h want %h/%h",
                  tag, a_cnt, b_cnt, ea, eb);
      end
   endtask

   task automatic test_reset();
      n_rst = 0; soft_rst = 0;
      mreq = 0; ioreq = 0; rd = 0; wr = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({a_rst, a_wait, a_mrd, a_mwr, a_ird, a_iwr} !== 6'b100000 ||
          {b_rst, b_wait} !== 2'b10 || a_cnt !== 16'h0 ||
          b_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_state got %b cnt %h want 100000 cnt 0000",
                  {a_rst, a_wait, a_mrd, a_mwr, a_ird, a_iwr}, a_cnt);
      end
      n_rst = 1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         checks++;
         if (a_rst !== (i < 8) || b_rst !== (i < 8)) begin
            errors++;
            $display("FAIL rst_release edge %0d got %b/%b want %b",
                     i, a_rst, b_rst, (i < 8));
         end
      end
   endtask

   task automatic test_mem_read();
      run_access(1, 0, 1, 0, 3, "mem_read");
   endtask

   task automatic test_io_write();
      run_access(0, 1, 0, 1, 6, "io_write");
      run_access(1, 1, 1, 0, 5, "io_wins");
   endtask

   task automatic test_abort();
      run_access(0, 1, 1, 0, 2, "abort");
      run_access(0, 1, 1, 0, 7, "after_abort");
   endtask

   task automatic test_back_to_back();
      run_access(1, 0, 0, 1, 1, "b2b_0");
      run_access(1, 0, 0, 1, 1, "b2b_1");
      run_access(1, 0, 0, 1, 3, "b2b_2");
   endtask

   task automatic test_soft_rst();
      ioreq = 1; wr = 1;
      #1;
      checks++;
      if (a_wait !== 1'b1) begin
         errors++;
         $display("FAIL srst_pre_wait got %b want 1", a_wait);
      end
      @(posedge clk); #1;
      soft_rst = 1;
      @(posedge clk); #1;
      soft_rst = 0;
      #1;
      checks++;
      if ({a_rst, a_wait, b_wait, a_iwr, b_iwr} !== 5'b10000) begin
         errors++;
         $display("FAIL srst_edge got %b want 10000",
                  {a_rst, a_wait, b_wait, a_iwr, b_iwr});
      end
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         checks++;
         if (a_rst !== (i < 8) || b_rst !== (i < 8)) begin
            errors++;
            $display("FAIL srst_seq edge %0d got %b/%b want %b",
                     i, a_rst, b_rst, (i < 8));
         end
      end
      @(posedge clk); #1;
      checks++;
      if ({a_wait, b_wait, a_iwr} !== 3'b001 || a_cnt !== cnt_a ||
          b_cnt !== cnt_b) begin
         errors++;
         $display("FAIL srst_stale got %b cnt %h want 001 cnt %h",
                  {a_wait, b_wait, a_iwr}, a_cnt, cnt_a);
      end
      ioreq = 0; wr = 0;
      @(posedge clk); #1;
      run_access(0, 1, 0, 1, 4, "srst_recover");
   endtask

   task automatic test_wrap();
      force u_a.acc_cnt = 16'hFFFE;
      #1;
      release u_a.acc_cnt;
      cnt_a = 16'hFFFE;
      run_access(1, 0, 1, 0, 1, "wrap_ffff");
      run_access(1, 0, 1, 0, 1, "wrap_0000");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_mem_read();
      test_io_write();
      test_abort();
      test_back_to_back();
      test_soft_rst();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
